regfile_sequencer: RTL

Micro-sequencer that owns all ports of the 4-entry x 32-bit register file and executes one simple register-to-register instruction at a time.
- Accepts instructions over a valid/ready handshake.
- Drives the read selects, computes the result in a small internal ALU, then drives the write port.
- Sits between the instruction source (test controller or future decoder) and the register file; nothing else writes the register file.

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/regfile_seq_alu.sv | 56 +++++
 rtl/regfile_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default widths for the register-file micro-sequencer.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int SEL_W_DEF  = 2;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_LOADI = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_AND   = 3'b100,
        OP_OR    = 3'b101,
        OP_XOR   = 3'b110,
        OP_MOV   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

endpackage

// File: rtl/regfile_seq_alu.sv
// Combinational ALU for the register-file sequencer.
// Optional macro REGFILE_SEQ_FLAGS_EN adds the carry/borrow output.
module regfile_seq_alu
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
`ifdef REGFILE_SEQ_FLAGS_EN
    output logic              carry,
`endif
    output logic [DATA_W-1:0] result
);

`ifdef REGFILE_SEQ_FLAGS_EN
    // One extra bit holds carry-out for ADD and borrow for SUB; zero otherwise.
    logic [DATA_W:0] wide;

    // Result and carry/borrow selected by opcode.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        wide = '0;
        case (op_e'(op))
            OP_LOADI: wide = {1'b0, imm};
            OP_ADD:   wide = {1'b0, a} + {1'b0, b};
            OP_SUB:   wide = {1'b0, a} - {1'b0, b};
            OP_AND:   wide = {1'b0, a & b};
            OP_OR:    wide = {1'b0, a | b};
            OP_XOR:   wide = {1'b0, a ^ b};
            OP_MOV:   wide = {1'b0, a};
            default:  wide = '0;
        endcase
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
    end
`else
    // Result selected by opcode; arithmetic wraps modulo 2^DATA_W.
    always_comb begin
        result = '0;
        case (op_e'(op))
            OP_LOADI: result = imm;
            OP_ADD:   result = a + b;
            OP_SUB:   result = a - b;
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            OP_MOV:   result = a;
            default:  result = '0;
        endcase
    end
`endif

endmodule

// File: rtl/regfile_sequencer.sv
// Micro-sequencer owning all ports of a 4 x 32 register file.
// Runs one instruction per three cycles: accept (IDLE), read+compute (EXEC),
// write-back (WRITE). Optional macro REGFILE_SEQ_FLAGS_EN adds the
// flag_zero / flag_carry outputs, registered alongside the result.
module regfile_sequencer
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [SEL_W-1:0]  instr_dest,
    input  logic [SEL_W-1:0]  instr_src_a,
    input  logic [SEL_W-1:0]  instr_src_b,
    input  logic [DATA_W-1:0] instr_imm,
    output logic [SEL_W-1:0]  rf_a_select,
    output logic [SEL_W-1:0]  rf_b_select,
    output logic [SEL_W-1:0]  rf_dest_select,
    output logic              rf_load_enable,
    output logic [DATA_W-1:0] rf_d_data,
    input  logic [DATA_W-1:0] rf_a_data,
    input  logic [DATA_W-1:0] rf_b_data,
`ifdef REGFILE_SEQ_FLAGS_EN
    output logic              flag_zero,
    output logic              flag_carry,
`endif
    output logic              busy,
    output logic              done
);

    state_e            state_q;
    state_e            state_d;
    logic [2:0]        op_q;
    logic [SEL_W-1:0]  dest_q;
    logic [SEL_W-1:0]  src_a_q;
    logic [SEL_W-1:0]  src_b_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] alu_result;
    logic              accept;
    logic              is_nop;

`ifdef REGFILE_SEQ_FLAGS_EN
    logic alu_carry;
`endif

    assign accept = instr_valid && instr_ready;
    assign is_nop = (op_e'(op_q) == OP_NOP);

    regfile_seq_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (op_q),
        .a      (rf_a_data),
        .b      (rf_b_data),
        .imm    (imm_q),
`ifdef REGFILE_SEQ_FLAGS_EN
        .carry  (alu_carry),
`endif
        .result (alu_result)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and handshake/control outputs; reset cycle forces everything inactive.
    always_comb begin
        state_d        = state_q;
        instr_ready    = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        rf_load_enable = 1'b0;
        case (state_q)
            ST_IDLE: begin
                instr_ready = !reset;
                if (accept) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                busy    = !reset;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                busy           = !reset;
                done           = !reset;
                rf_load_enable = !reset && !is_nop;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Instruction field latches, loaded only on the accept cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q    <= '0;
            dest_q  <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
            imm_q   <= '0;
        end else if (accept) begin
            op_q    <= instr_op;
            dest_q  <= instr_dest;
            src_a_q <= instr_src_a;
            src_b_q <= instr_src_b;
            imm_q   <= instr_imm;
        end
    end

    // Result register (and flags) captured at the end of EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q   <= '0;
`ifdef REGFILE_SEQ_FLAGS_EN
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
`endif
        end else if (state_q == ST_EXEC) begin
            result_q   <= alu_result;
`ifdef REGFILE_SEQ_FLAGS_EN
            if (!is_nop) begin
                flag_zero  <= (alu_result == '0);
                flag_carry <= alu_carry;
            end
`endif
        end
    end

    // Selects and write data come straight from the latches, so they hold in IDLE.
    assign rf_a_select    = src_a_q;
    assign rf_b_select    = src_b_q;
    assign rf_dest_select = dest_q;
    assign rf_d_data      = result_q;

endmodule
